// File: rtl/priority_grant_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | priority_grant_sequencer: encoder result -> offer/hold/release transaction  |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module priority_grant_sequencer #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enc_valid,
  input  logic [IDX_W-1:0]   enc_index,
  output logic               grant_valid,
  input  logic               grant_ready,
  output logic [IDX_W-1:0]   grant_index,
  output logic [NUM_REQ-1:0] grant,
  // "release" is a reserved word in SystemVerilog, hence the longer name
  input  logic               grant_release,
  output logic [NUM_REQ-1:0] clear_req,
  output logic               timeout,
  output logic               err_index,
  output logic               busy
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             index_ok;

  assign index_ok = (32'(enc_index) < NUM_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      grant_index <= '0;
      grant_valid <= 1'b0;
      grant       <= '0;
      clear_req   <= '0;
      timeout     <= 1'b0;
      err_index   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      clear_req <= '0;
      timeout   <= 1'b0;
      err_index <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enc_valid) begin
            if (index_ok) begin
              grant_index <= enc_index;
              grant_valid <= 1'b1;
              busy        <= 1'b1;
              state       <= S_OFFER;
            end else begin
              err_index <= 1'b1;
            end
          end
        end
        S_OFFER: begin
          if (grant_ready) begin
            grant_valid <= 1'b0;
            grant       <= ONE << grant_index;
            hold_cnt    <= '0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Release takes priority over expiry arriving in the same cycle.
          if (grant_release || hold_cnt == HOLD_LAST) begin
            grant     <= '0;
            clear_req <= ONE << grant_index;
            timeout   <= ~grant_release;
            state     <= S_DONE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
